// File: rtl/req_arbiter_pkg.sv
// req_arbiter_pkg
// Shared definitions for the two-master request arbiter: FSM state
// encoding, owner index constants and outstanding-counter sizing.
package req_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_A = 2'd1,
    S_OWN_B = 2'd2
  } state_t;

  // Owner index doubles as the bit position in the per-master vectors.
  typedef logic owner_t;
  localparam owner_t OWN_A = 1'b0;
  localparam owner_t OWN_B = 1'b1;

  localparam int OUT_W = 4;
  localparam logic [OUT_W-1:0] OUT_MAX = 4'd15;

endpackage

// File: rtl/req_arbiter_if.sv
// req_arbiter_if
// Bundles the two-master Wishbone-style request bus and the shared slave
// bus seen by req_arbiter.
//   i_m_cyc/stb/we/addr [1:0]  per-master request (bit 0 = A, bit 1 = B)
//   i_m_data [2*DW-1:0]        write data, A low half, B high half
//   o_m_stall/ack/err [1:0]    per-master responses
//   o_m_data [DW-1:0]          shared read data, valid with o_m_ack
//   o_s_cyc/stb/we/addr        slave request, muxed from the owner
//   o_s_data [DW-1:0]          slave write data
//   i_s_stall/ack, i_s_data    slave handshake and read data
// Modports: slave = arbiter view, master = environment (masters + slave).
interface req_arbiter_if #(
  parameter int DW = 32
);
  logic [1:0]      i_m_cyc;
  logic [1:0]      i_m_stb;
  logic [1:0]      i_m_we;
  logic [1:0]      i_m_addr;
  logic [2*DW-1:0] i_m_data;
  logic [1:0]      o_m_stall;
  logic [1:0]      o_m_ack;
  logic [1:0]      o_m_err;
  logic [DW-1:0]   o_m_data;
  logic            o_s_cyc;
  logic            o_s_stb;
  logic            o_s_we;
  logic            o_s_addr;
  logic [DW-1:0]   o_s_data;
  logic            i_s_stall;
  logic            i_s_ack;
  logic [DW-1:0]   i_s_data;

  modport slave (
    input  i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_data,
    input  i_s_stall, i_s_ack, i_s_data,
    output o_m_stall, o_m_ack, o_m_err, o_m_data,
    output o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data
  );

  modport master (
    output i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_data,
    output i_s_stall, i_s_ack, i_s_data,
    input  o_m_stall, o_m_ack, o_m_err, o_m_data,
    input  o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data
  );
endinterface

// File: rtl/req_arb_timer.sv
// req_arb_timer
// Slave-ack watchdog. Down-counter reloaded with TIMEOUT_CYCLES whenever
// i_run is low; while i_run stays high it counts down and o_expired is
// asserted once TIMEOUT_CYCLES consecutive run cycles have elapsed.
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_run           requests outstanding and no ack this cycle
//   o_expired       terminal count reached while still running
module req_arb_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  output logic o_expired
);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] remain_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_run) begin
      remain_q <= TW'(TIMEOUT_CYCLES);
    end else if (remain_q != '0) begin
      remain_q <= remain_q - TW'(1);
    end
  end

  assign o_expired = i_run && (remain_q == '0);

endmodule

// File: rtl/req_arbiter.sv
// req_arbiter
// Two-master to one-slave arbiter with registered grant and alternating
// priority on ties. The owner's request is passed to the slave, acks are
// returned combinationally to the owner only, and an outstanding-request
// counter (max 15) throttles strobes.
//   i_clk    sole clock (rising edge)
//   i_reset  synchronous active-high reset
//   bus      req_arbiter_if.slave, see interface header for signals
// Optional: define ARB_TIMEOUT_EN to add the slave-ack watchdog
// (req_arb_timer); on expiry the owner gets a one-clock o_m_err, the bus
// is released and that master is locked out until it drops cyc.
module req_arbiter
  import req_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int DW             = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  req_arbiter_if.slave  bus
);

  state_t           state_q, state_d;
  owner_t           last_q;
  logic [OUT_W-1:0] out_q, out_d;
  owner_t           own;
  logic             owning;
  logic             full;
  logic             timeout;
  logic [1:0]       blocked;
  logic [1:0]       req;
  logic             ack_in;
  logic             accept;
  logic [DW-1:0]    wdata_a, wdata_b;

  logic             s_cyc, s_stb, s_we, s_addr;
  logic [DW-1:0]    s_data;
  logic [1:0]       m_stall, m_ack, m_err;

  assign owning  = (state_q != S_IDLE);
  assign own     = (state_q == S_OWN_B) ? OWN_B : OWN_A;
  assign full    = (out_q == OUT_MAX);
  assign req     = bus.i_m_cyc & ~blocked;
  assign ack_in  = owning && bus.i_s_ack;
  assign accept  = s_stb && !bus.i_s_stall;
  assign wdata_a = bus.i_m_data[DW-1:0];
  assign wdata_b = bus.i_m_data[2*DW-1:DW];

  always_comb begin
    state_d = state_q;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_addr  = 1'b0;
    s_data  = '0;
    m_stall = 2'b11;
    m_ack   = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (req[OWN_A] && req[OWN_B]) begin
          state_d = (last_q == OWN_A) ? S_OWN_B : S_OWN_A;
        end else if (req[OWN_A]) begin
          state_d = S_OWN_A;
        end else if (req[OWN_B]) begin
          state_d = S_OWN_B;
        end
      end
      S_OWN_A, S_OWN_B: begin
        // On watchdog expiry the bus is released in the same cycle.
        s_cyc        = bus.i_m_cyc[own] && !timeout;
        s_stb        = bus.i_m_stb[own] && !full && !timeout;
        s_we         = bus.i_m_we[own];
        s_addr       = bus.i_m_addr[own];
        s_data       = (own == OWN_B) ? wdata_b : wdata_a;
        m_stall[own] = bus.i_s_stall || full;
        m_ack[own]   = bus.i_s_ack;
        if (!bus.i_m_cyc[own] || timeout) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Simultaneous accept and ack cancel; saturate at both ends.
  always_comb begin
    out_d = out_q;
    if (accept && !ack_in && !full) begin
      out_d = out_q + OUT_W'(1);
    end else if (ack_in && !accept && (out_q != '0)) begin
      out_d = out_q - OUT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      last_q  <= OWN_B;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= (state_d == S_IDLE) ? '0 : out_d;
      if (state_q == S_IDLE && state_d != S_IDLE) begin
        last_q <= (state_d == S_OWN_B) ? OWN_B : OWN_A;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic       timer_run;
  logic [1:0] blocked_q;
  logic [1:0] err_set;

  assign timer_run = owning && (out_q != '0) && !bus.i_s_ack;

  req_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_run     (timer_run),
    .o_expired (timeout)
  );

  always_comb begin
    err_set = 2'b00;
    if (timeout) begin
      err_set[own] = 1'b1;
    end
  end

  // A timed-out master stays locked out until it drops cyc.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      blocked_q <= 2'b00;
    end else begin
      blocked_q <= (blocked_q | err_set) & bus.i_m_cyc;
    end
  end

  assign blocked = blocked_q;
  assign m_err   = err_set;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign blocked = 2'b00;
  assign m_err   = 2'b00;
`endif

  assign bus.o_s_cyc   = s_cyc;
  assign bus.o_s_stb   = s_stb;
  assign bus.o_s_we    = s_we;
  assign bus.o_s_addr  = s_addr;
  assign bus.o_s_data  = s_data;
  assign bus.o_m_stall = m_stall;
  assign bus.o_m_ack   = m_ack;
  assign bus.o_m_err   = m_err;
  assign bus.o_m_data  = bus.i_s_data;

endmodule

// File: tb/tb_req_arbiter.sv
module tb_req_arbiter;
  localparam int DW = 32;
  localparam int TO = 15;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  req_arbiter_if #(.DW(DW)) bus_if ();

  req_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .DW(DW)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus_if)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic [31:0] da;
    logic [31:0] db;
    logic        sst;
    logic        sack;
    logic [1:0]  x_stall;
    logic [1:0]  x_ack;
    logic        x_scyc;
    logic        x_sstb;
    logic        x_swe;
    logic        x_saddr;
    logic [31:0] x_sdata;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic rst, input logic [1:0] cyc, input logic [1:0] stb,
                     input logic [31:0] da, input logic [31:0] db,
                     input logic sst, input logic sack,
                     input logic [1:0] x_stall, input logic [1:0] x_ack,
                     input logic x_scyc, input logic x_sstb, input logic x_swe,
                     input logic x_saddr, input logic [31:0] x_sdata);
    vec_t v;
    v.rst = rst; v.cyc = cyc; v.stb = stb; v.da = da; v.db = db;
    v.sst = sst; v.sack = sack; v.x_stall = x_stall; v.x_ack = x_ack;
    v.x_scyc = x_scyc; v.x_sstb = x_sstb; v.x_swe = x_swe;
    v.x_saddr = x_saddr; v.x_sdata = x_sdata;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic [1:0] cyc, input logic [1:0] stb,
                       input logic [31:0] da, input logic [31:0] db,
                       input logic sst, input logic sack, input logic [31:0] sd);
    i_reset          = rst;
    bus_if.i_m_cyc   = cyc;
    bus_if.i_m_stb   = stb;
    bus_if.i_m_we    = 2'b01;   // A writes, B reads
    bus_if.i_m_addr  = 2'b10;   // A addr 0, B addr 1
    bus_if.i_m_data  = {db, da};
    bus_if.i_s_stall = sst;
    bus_if.i_s_ack   = sack;
    bus_if.i_s_data  = sd;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "tb timeout");
  end

  initial begin
    // rst cyc    stb    da     db     sst   sack | stall ack  scyc  sstb  swe   saddr sdata
    add(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 2'b01, 2'b01, 32'h5, 32'h0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 2'b01, 2'b01, 32'h5, 32'h0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 32'h5);
    add(1'b0, 2'b01, 2'b00, 32'h5, 32'h0, 1'b0, 1'b1, 2'b10, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 32'h5);
    add(1'b0, 2'b00, 2'b00, 32'h5, 32'h0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5);
    add(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    add(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 2'b11, 2'b00, 32'h1, 32'h2, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1);
    add(1'b0, 2'b10, 2'b00, 32'h1, 32'h2, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1);
    add(1'b0, 2'b10, 2'b00, 32'h1, 32'h2, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 2'b10, 2'b10, 32'h0, 32'h7, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h7);
    add(1'b0, 2'b11, 2'b00, 32'h0, 32'h7, 1'b1, 1'b1, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 32'h7);
    add(1'b0, 2'b01, 2'b00, 32'h0, 32'h7, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7);
    add(1'b0, 2'b11, 2'b00, 32'h3, 32'h4, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 2'b11, 2'b00, 32'h3, 32'h4, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3);
    add(1'b0, 2'b10, 2'b00, 32'h3, 32'h4, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3);
    add(1'b0, 2'b11, 2'b00, 32'h3, 32'h4, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 2'b11, 2'b00, 32'h3, 32'h4, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4);
    add(1'b0, 2'b00, 2'b00, 32'h3, 32'h4, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4);
    add(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    do_reset();

    foreach (vecs[i]) begin
      logic [31:0] sd;
      sd = 32'hA500_0000 + 32'(i);
      drive(vecs[i].rst, vecs[i].cyc, vecs[i].stb, vecs[i].da, vecs[i].db,
            vecs[i].sst, vecs[i].sack, sd);
      #1;
      chk($sformatf("vec%0d ctl", i),
          {56'h0, bus_if.o_m_stall, bus_if.o_m_ack, bus_if.o_s_cyc, bus_if.o_s_stb},
          {56'h0, vecs[i].x_stall, vecs[i].x_ack, vecs[i].x_scyc, vecs[i].x_sstb});
      chk($sformatf("vec%0d s_we_addr_data_err", i),
          {28'h0, bus_if.o_m_err, bus_if.o_s_we, bus_if.o_s_addr, bus_if.o_s_data},
          {28'h0, 2'b00, vecs[i].x_swe, vecs[i].x_saddr, vecs[i].x_sdata});
      chk($sformatf("vec%0d m_data", i), {32'h0, bus_if.o_m_data}, {32'h0, sd});
      next_cycle();
    end

`ifndef ARB_TIMEOUT_EN
    // Backpressure: slave never acks, 15 accepted then stalled.
    do_reset();
    drive(1'b0, 2'b01, 2'b01, 32'h9, 32'h0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    for (int k = 0; k < 15; k++) begin
      #1;
      chk($sformatf("bp accept%0d stb_stall", k),
          {61'h0, bus_if.o_s_stb, bus_if.o_m_stall}, {61'h0, 1'b1, 2'b10});
      next_cycle();
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp full%0d stb_stall", k),
          {61'h0, bus_if.o_s_stb, bus_if.o_m_stall}, {61'h0, 1'b0, 2'b11});
      next_cycle();
    end
    drive(1'b0, 2'b01, 2'b01, 32'h9, 32'h0, 1'b0, 1'b1, 32'h0);
    #1;
    chk("bp ack at full", {60'h0, bus_if.o_m_ack, bus_if.o_s_stb, 1'b0},
        {60'h0, 2'b01, 1'b0, 1'b0});
    next_cycle();
    #1;
    chk("bp accept+ack", {61'h0, bus_if.o_s_stb, bus_if.o_m_stall}, {61'h0, 1'b1, 2'b10});
    next_cycle();
    drive(1'b0, 2'b01, 2'b01, 32'h9, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("bp last accept", {61'h0, bus_if.o_s_stb, bus_if.o_m_stall}, {61'h0, 1'b1, 2'b10});
    next_cycle();
    #1;
    chk("bp full again", {61'h0, bus_if.o_s_stb, bus_if.o_m_stall}, {61'h0, 1'b0, 2'b11});
    next_cycle();
`endif

    // Reset in OWN_B with 3 outstanding; late ack must be dropped.
    do_reset();
    drive(1'b0, 2'b10, 2'b10, 32'h0, 32'h8, 1'b0, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
    next_cycle();
    #1;
    chk("mid owner B", {62'h0, bus_if.o_s_cyc, bus_if.o_s_stb}, {62'h0, 1'b1, 1'b1});
    next_cycle();
    drive(1'b1, 2'b10, 2'b00, 32'h0, 32'h8, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 2'b10, 2'b00, 32'h0, 32'h8, 1'b0, 1'b1, 32'h0);
    #1;
    chk("mid reset", {59'h0, bus_if.o_s_cyc, bus_if.o_m_stall, bus_if.o_m_ack},
        {59'h0, 1'b0, 2'b11, 2'b00});
    next_cycle();

`ifdef ARB_TIMEOUT_EN
    do_reset();
    drive(1'b0, 2'b01, 2'b01, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    #1;
    chk("to accept", {63'h0, bus_if.o_s_stb}, {63'h0, 1'b1});
    next_cycle();
    drive(1'b0, 2'b01, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= TO; k++) begin
      #1;
      chk($sformatf("to wait%0d", k), {61'h0, bus_if.o_m_err, bus_if.o_s_cyc},
          {61'h0, 2'b00, 1'b1});
      next_cycle();
    end
    #1;
    chk("to expire", {61'h0, bus_if.o_m_err, bus_if.o_s_cyc}, {61'h0, 2'b01, 1'b0});
    next_cycle();
    drive(1'b0, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("to idle", {60'h0, bus_if.o_m_err, bus_if.o_m_stall}, {60'h0, 2'b00, 2'b11});
    next_cycle();
    #1;
    chk("to B granted", {61'h0, bus_if.o_m_stall, bus_if.o_s_cyc}, {61'h0, 2'b01, 1'b1});
    next_cycle();
    drive(1'b0, 2'b01, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("to A locked%0d", k), {62'h0, bus_if.o_m_stall}, {62'h0, 2'b11});
      next_cycle();
    end
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 2'b01, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    #1;
    chk("to A regranted", {62'h0, bus_if.o_m_stall}, {62'h0, 2'b10});
    next_cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: slave-ack watchdog limit in clocks (used only under ARB_TIMEOUT_EN).
REQ-002 Parameter DW, default 32: bus data width.
REQ-003 i_clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 i_reset  in  1  reset, synchronous, active-high.
REQ-005 i_m_cyc  in  2  per-master Wishbone cycle; bit 0 = master A, bit 1 = master B.
REQ-006 i_m_stb  in  2  per-master strobe.
REQ-007 i_m_we  in  2  per-master write enable.
REQ-008 i_m_addr  in  2  per-master 1-bit address.
REQ-009 i_m_data  in  2*DW  write data; A in [DW-1:0], B in [2*DW-1:DW].
REQ-010 o_m_stall  out  2  per-master stall.
REQ-011 o_m_ack  out  2  per-master ack.
REQ-012 o_m_err  out  2  per-master bus error.
REQ-013 o_m_data  out  DW  read data, shared, valid only with o_m_ack.
REQ-014 o_s_cyc, o_s_stb, o_s_we, o_s_addr  out  1 each  slave-side request, muxed from owner.
REQ-015 o_s_data  out  DW  slave write data, muxed from owner.
REQ-016 i_s_stall, i_s_ack  in  1 each  slave handshake.
REQ-017 i_s_data  in  DW  slave read data.

Function
REQ-018 FSM states IDLE, OWN_A, OWN_B; grant SHALL be registered.
REQ-019 IDLE: one master with cyc -> its OWN state next clock; both -> master that was NOT last owner; neither -> stay IDLE.
REQ-020 OWN_x -> IDLE on the clock after owner's cyc falls; no direct OWN_A <-> OWN_B transition (one IDLE clock between owners).
REQ-021 In OWN_x: o_s_cyc = owner cyc; o_s_stb = owner stb gated by (outstanding < 15); o_s_we/addr/data = owner's.
REQ-022 o_m_stall: owner sees i_s_stall OR (outstanding == 15); non-owner and every master in IDLE see 1.
REQ-023 o_m_ack = i_s_ack routed to owner only; o_m_data = i_s_data; acks arriving in IDLE SHALL be dropped.
REQ-024 Outstanding counter, 4 bits: +1 on accepted stb (o_s_stb & !i_s_stall), -1 on i_s_ack, unchanged on both together; no wrap at 0 or 15; cleared on entering IDLE.
REQ-025 Latency: master stb in cycle N while IDLE -> o_s_stb in N+1; ack -> master same cycle (combinational return).
REQ-026 Last-owner register SHALL update on each OWN_x entry.

Reset
REQ-027 i_reset SHALL force IDLE, outstanding = 0, last owner = B (A wins first tie), all o_m_ack/o_m_err = 0, o_s_cyc = o_s_stb = 0, o_m_stall = 2'b11, mid-transaction included; in-flight acks discarded.

Configuration
REQ-028 With ARB_TIMEOUT_EN defined: counter runs while outstanding > 0 with no i_s_ack, cleared otherwise; on reaching TIMEOUT_CYCLES, pulse owner o_m_err one clock, drop o_s_cyc, go IDLE; that master SHALL NOT be regranted until its cyc falls.
REQ-029 Without ARB_TIMEOUT_EN: o_m_err tied 2'b00, no timer logic, TIMEOUT_CYCLES ignored.

Structure
REQ-030 Package req_arbiter_pkg holds the state encoding, owner index constants (OWN_A = 0, OWN_B = 1) and outstanding-counter width.
REQ-031 Sub-module req_arb_timer SHALL implement the watchdog, instantiated only under ARB_TIMEOUT_EN.

Verification
REQ-032 A alone: A cyc+stb write data 0x5 -> o_s_stb next clock with o_s_data 0x5; slave ack -> o_m_ack = 2'b01 same clock.
REQ-033 Tie after reset: A, B raise cyc same clock -> OWN_A; A drops cyc -> one IDLE clock -> OWN_B; B stalled (o_m_stall[1] = 1) throughout OWN_A.
REQ-034 Round robin: repeat tie after B owned -> A granted; after A owned -> B granted.
REQ-035 Backpressure: slave holds i_s_stall = 0 and never acks, 15 strobes accepted -> 16th stalled, counter holds 15; simultaneous stb accept + ack -> counter unchanged.
REQ-036 Reset mid-transfer: i_reset in OWN_B with 3 outstanding -> next clock IDLE, o_s_cyc = 0, late ack not forwarded.
REQ-037 ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 15: A issues 1 stb, no ack for 15 clocks -> o_m_err = 2'b01 one clock, o_s_cyc = 0; A kept cyc -> B granted next tie, A not regranted until cyc falls.
